// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared encodings and default widths for the mult/div controller
package multdiv_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 5;
    localparam int TIMEOUT_DEF = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_controller_if.sv
// rtl/multdiv_controller_if.sv - request, unit and writeback signals of the mult/div controller
interface multdiv_controller_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              req_valid;
    logic              req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [REG_W-1:0]  req_rd;
    logic              req_ready;
    logic              stall;
    logic [DATA_W-1:0] unit_operandA;
    logic [DATA_W-1:0] unit_operandB;
    logic              unit_ctrl_MULT;
    logic              unit_ctrl_DIV;
    logic [DATA_W-1:0] unit_result;
    logic              unit_exception;
    logic              unit_resultRDY;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_exception;
    logic              wb_ack;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd,
        input  unit_result, unit_exception, unit_resultRDY, wb_ack,
        output req_ready, stall, unit_operandA, unit_operandB,
        output unit_ctrl_MULT, unit_ctrl_DIV,
        output wb_valid, wb_rd, wb_data, wb_exception
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd,
        output unit_result, unit_exception, unit_resultRDY, wb_ack,
        input  req_ready, stall, unit_operandA, unit_operandB,
        input  unit_ctrl_MULT, unit_ctrl_DIV,
        input  wb_valid, wb_rd, wb_data, wb_exception
    );

endinterface

// File: rtl/multdiv_timeout_counter.sv
// rtl/multdiv_timeout_counter.sv - bounded WAIT-cycle counter that flags when TIMEOUT cycles have passed
module multdiv_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles; saturate once the limit is reached so expired stays high.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Count value k means k+1 cycles have been spent once the current one ends.
    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_controller.sv
// rtl/multdiv_controller.sv - sequences the shared iterative mult/div unit (optional abort: MULTDIV_TIMEOUT_EN)
module multdiv_controller
    import multdiv_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_controller_if.slave  bus
);

    state_t            state;
    logic              op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_exc_q;
    logic              timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
    multdiv_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expired (timeout_hit)
    );
`else
    // WAIT never aborts in this build; the comparison is false for any legal TIMEOUT.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // Main sequencer: latch the request, pulse start, collect the result, hand it to writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        rd_q  <= bus.req_rd;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // resultRDY may still be high from the previous op, so it is not looked at here.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.unit_resultRDY) begin
                        wb_data_q <= bus.unit_result;
                        wb_exc_q  <= bus.unit_exception;
                        // Writes to r0 are discarded without troubling writeback.
                        state     <= (rd_q != '0) ? ST_DONE : ST_IDLE;
                    end else if (timeout_hit) begin
                        wb_data_q <= '0;
                        wb_exc_q  <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    if (bus.wb_ack) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready      = (state == ST_IDLE);
    assign bus.stall          = bus.req_valid && (state != ST_IDLE);
    assign bus.unit_operandA  = a_q;
    assign bus.unit_operandB  = b_q;
    assign bus.unit_ctrl_MULT = (state == ST_ISSUE) && (op_q == OP_MULT);
    assign bus.unit_ctrl_DIV  = (state == ST_ISSUE) && (op_q == OP_DIV);
    assign bus.wb_valid       = (state == ST_DONE);
    assign bus.wb_rd          = rd_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.wb_exception   = wb_exc_q;

endmodule

// File: tb/tb_multdiv_controller.sv
// tb/tb_multdiv_controller.sv - self-checking bench for multdiv_controller
module tb_multdiv_controller;
    import multdiv_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 64;

    typedef struct {
        logic          op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] rd;
        int            lat;
        logic [DW-1:0] exp_data;
        logic          exp_exc;
        bit            exp_wb;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    multdiv_controller_if #(.DATA_W(DW), .REG_W(RW)) bus ();

    multdiv_controller #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Unit model: latency counted from the negedge where the start pulse is seen; lat 0 = never ready.
    int            u_lat = 1;
    int            u_cnt = 0;
    logic [DW-1:0] u_res;
    logic          u_exc;

    initial begin
        bus.unit_resultRDY = 1'b0;
        bus.unit_result    = '0;
        bus.unit_exception = 1'b0;
        forever begin
            @(negedge clock);
            bus.unit_resultRDY = 1'b0;
            if (u_cnt > 0) begin
                u_cnt--;
                if (u_cnt == 0) begin
                    bus.unit_resultRDY = 1'b1;
                    bus.unit_result    = u_res;
                    bus.unit_exception = u_exc;
                end
            end
            if ((bus.unit_ctrl_MULT === 1'b1 || bus.unit_ctrl_DIV === 1'b1) && u_lat > 0) begin
                u_cnt = u_lat;
                if (bus.unit_ctrl_MULT === 1'b1) begin
                    u_res = bus.unit_operandA * bus.unit_operandB;
                    u_exc = 1'b0;
                end else if (bus.unit_operandB == '0) begin
                    u_res = '0;
                    u_exc = 1'b1;
                end else begin
                    u_res = bus.unit_operandA / bus.unit_operandB;
                    u_exc = 1'b0;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx, input int exp_k);
        int   wb_k;
        int   n_mul;
        int   n_div;
        bit   seen;
        bit   ops_ok;
        bit   busy_ok;
        bit   hold_ok;
        u_lat = v.lat;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_rd    = v.rd;
        bus.req_valid = 1'b1;
        n_mul = 0; n_div = 0; seen = 0; ops_ok = 1; busy_ok = 1; wb_k = -1;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(negedge clock);
            if (k == 1) bus.req_valid = 1'b0;
            n_mul += int'(bus.unit_ctrl_MULT);
            n_div += int'(bus.unit_ctrl_DIV);
            if (v.exp_wb ? (bus.wb_valid === 1'b1) : (bus.req_ready === 1'b1)) begin
                seen = 1;
                wb_k = k;
            end
            if (!seen || v.exp_wb) begin
                if (bus.unit_operandA !== v.a || bus.unit_operandB !== v.b) ops_ok = 0;
            end
            if (!seen && (bus.req_ready !== 1'b0 || bus.wb_valid !== 1'b0)) busy_ok = 0;
        end
        chk($sformatf("v%0d_latency", idx), 64'(wb_k), 64'(exp_k));
        chk($sformatf("v%0d_mult_pulses", idx), 64'(n_mul), (v.op == OP_MULT) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d_div_pulses", idx), 64'(n_div), (v.op == OP_DIV) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d_operands_held", idx), 64'(ops_ok), 64'd1);
        chk($sformatf("v%0d_busy_flags", idx), 64'(busy_ok), 64'd1);
        if (v.exp_wb) begin
            chk($sformatf("v%0d_wb_data", idx), 64'(bus.wb_data), 64'(v.exp_data));
            chk($sformatf("v%0d_wb_exc", idx), 64'(bus.wb_exception), 64'(v.exp_exc));
            chk($sformatf("v%0d_wb_rd", idx), 64'(bus.wb_rd), 64'(v.rd));
            hold_ok = 1;
            for (int k = 0; k < 3; k++) begin
                if (k == 2) bus.wb_ack = 1'b1;
                @(negedge clock);
                if (k < 2 && (bus.wb_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                              bus.wb_data !== v.exp_data || bus.wb_rd !== v.rd)) hold_ok = 0;
            end
            bus.wb_ack = 1'b0;
            chk($sformatf("v%0d_done_hold", idx), 64'(hold_ok), 64'd1);
            chk($sformatf("v%0d_after_ack", idx), {62'd0, bus.req_ready, bus.wb_valid}, 64'b10);
        end else begin
            chk($sformatf("v%0d_no_wb", idx), 64'(bus.wb_valid), 64'd0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        bit   ok;
        int   k;
        vecs[0] = '{OP_MULT, 32'd7,          32'd6,  5'd3,  8, 32'd42,         1'b0, 1'b1};
        vecs[1] = '{OP_DIV,  32'd100,        32'd0,  5'd5,  4, 32'd0,          1'b1, 1'b1};
        vecs[2] = '{OP_DIV,  32'd100,        32'd7,  5'd31, 1, 32'd14,         1'b0, 1'b1};
        vecs[3] = '{OP_MULT, 32'd3,          32'd3,  5'd0,  3, 32'd9,          1'b0, 1'b0};
        vecs[4] = '{OP_MULT, 32'hFFFF_FFFF,  32'd2,  5'd1,  2, 32'hFFFF_FFFE,  1'b0, 1'b1};
        vecs[5] = '{OP_DIV,  32'hFFFF_FFFF,  32'd16, 5'd17, 6, 32'h0FFF_FFFF,  1'b0, 1'b1};

        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_rd    = '0;
        bus.wb_ack    = 1'b0;

        // reset state
        repeat (2) @(negedge clock);
        chk("reset_flags", {58'd0, bus.req_ready, bus.stall, bus.wb_valid, bus.unit_ctrl_MULT,
                            bus.unit_ctrl_DIV, bus.wb_exception}, 64'b100000);
        chk("reset_operands", {bus.unit_operandA, bus.unit_operandB}, 64'd0);
        chk("reset_wb", {27'd0, bus.wb_rd, bus.wb_data}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i, vecs[i].lat + 2);

        // back-to-back: second request held valid while the first is in flight
        u_lat = 3;
        bus.req_op = OP_MULT; bus.req_a = 32'd5; bus.req_b = 32'd9; bus.req_rd = 5'd7;
        bus.req_valid = 1'b1;
        @(negedge clock);
        bus.req_op = OP_DIV; bus.req_a = 32'd81; bus.req_b = 32'd9; bus.req_rd = 5'd8;
        ok = 1;
        for (k = 0; k < 50 && bus.wb_valid !== 1'b1; k++) begin
            if (bus.stall !== 1'b1 || bus.req_ready !== 1'b0 ||
                bus.unit_operandA !== 32'd5 || bus.unit_operandB !== 32'd9) ok = 0;
            @(negedge clock);
        end
        chk("b2b_busy_stall", 64'(ok), 64'd1);
        chk("b2b_first_data", {27'd0, bus.wb_rd, bus.wb_data}, {27'd0, 5'd7, 32'd45});
        chk("b2b_first_ops_done", {bus.unit_operandA, bus.unit_operandB}, {32'd5, 32'd9});
        bus.wb_ack = 1'b1;
        @(negedge clock);
        bus.wb_ack = 1'b0;
        u_lat = 2;
        chk("b2b_ready_after_ack", {62'd0, bus.req_ready, bus.stall}, 64'b10);
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("b2b_second_issue", {62'd0, bus.unit_ctrl_DIV, bus.unit_ctrl_MULT}, 64'b10);
        chk("b2b_second_ops", {bus.unit_operandA, bus.unit_operandB}, {32'd81, 32'd9});
        for (k = 0; k < 50 && bus.wb_valid !== 1'b1; k++) @(negedge clock);
        chk("b2b_second_data", {27'd0, bus.wb_rd, bus.wb_data}, {27'd0, 5'd8, 32'd9});
        bus.wb_ack = 1'b1;
        @(negedge clock);
        bus.wb_ack = 1'b0;

        // reset while in WAIT; the unit answers later and must be ignored
        u_lat = 10;
        bus.req_op = OP_MULT; bus.req_a = 32'd4; bus.req_b = 32'd4; bus.req_rd = 5'd2;
        bus.req_valid = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_wait_flags", {59'd0, bus.req_ready, bus.wb_valid, bus.unit_ctrl_MULT,
                               bus.unit_ctrl_DIV, bus.stall}, 64'b10000);
        chk("rst_wait_operands", {bus.unit_operandA, bus.unit_operandB}, 64'd0);
        ok = 1;
        for (k = 0; k < 15; k++) begin
            @(negedge clock);
            if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0) ok = 0;
        end
        chk("rst_late_rdy_ignored", 64'(ok), 64'd1);

`ifdef MULTDIV_TIMEOUT_EN
        // unit never answers: abort reported after TIMEOUT WAIT cycles, even for rd 0
        v = '{OP_MULT, 32'd1, 32'd1, 5'd0, 0, 32'd0, 1'b1, 1'b1};
        run_vec(v, 99, TO + 2);
`else
        v = vecs[0];
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
